hs_rr_arbiter: RTL
==================

HS_RR_ARBITER -- requirements
Module: hs_rr_arbiter

Interface
REQ-001 SHALL have parameter DW, default 3, meaning data width per channel.
REQ-002 SHALL have parameter N, default 4, meaning number of upstream requesters (2..8).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port valid_i  input  N  per-requester valid.
REQ-006 SHALL have port ready_o  output  N  per-requester ready.
REQ-007 SHALL have port din  input  N*DW  requester k data at bits [k*DW +: DW].
REQ-008 SHALL have port valid_o  output  1  downstream valid.
REQ-009 SHALL have port ready_i  input  1  downstream ready.
REQ-010 SHALL have port dout  output  DW  registered downstream data.
REQ-011 SHALL have port gnt_id_o  output  clog2(N)  source index of data held in dout.
REQ-012 SHALL have port last_i  input  N  per-requester end-of-packet; present only when HS_ARB_LOCK_EN is defined.

Function
REQ-013 SHALL hold one output register stage (full flag, dout, gnt_id_o); valid_o = full.
REQ-014 SHALL compute wr_en = ~full | ready_i combinationally from the current-cycle ready_i (no delayed ready).
REQ-015 SHALL select winner combinationally: first asserted valid_i scanning from pointer ptr upward, wrapping N-1 -> 0.
REQ-016 SHALL drive ready_o[k] = wr_en & (winner == k) & valid_i[k]; at most one ready_o bit high per cycle.
REQ-017 SHALL, when wr_en & any valid_i, load dout <= din[winner], gnt_id_o <= winner, full <= 1 on the clock edge (accept-to-valid_o latency 1 cycle).
REQ-018 SHALL, when wr_en & no valid_i, clear full and hold dout and gnt_id_o.
REQ-019 SHALL, when ~wr_en (full & ~ready_i), hold full, dout, gnt_id_o stable.
REQ-020 SHALL, on each accept from requester k (unlocked), update ptr <= (k+1) mod N; ptr unchanged otherwise.
REQ-021 SHALL sustain one transfer per cycle when ready_i is held high and any valid_i is high.
REQ-022 SHALL treat a requester deasserting valid_i without being granted as legal; arbitration is re-evaluated every cycle.
REQ-023 SHALL use ptr width clog2(N); wrap uses explicit modulo-N for non-power-of-two N.

Reset
REQ-024 SHALL on rst_n low asynchronously set full=0, dout=0, gnt_id_o=0, ptr=0, lock FSM=IDLE, owner=0.
REQ-025 SHALL drive valid_o=0 and ready_o=0 while rst_n is low; reset mid-packet discards the lock and any held beat.
REQ-026 SHALL resume arbitration on the first rising edge after rst_n deasserts, starting from requester 0.

Configuration
REQ-027 SHALL, when HS_ARB_LOCK_EN is defined, implement packet lock FSM with states IDLE and LOCKED and register owner.
REQ-028 SHALL, in IDLE, on accept from k with last_i[k]=0, go to LOCKED with owner=k; with last_i[k]=1, stay IDLE and advance ptr per REQ-020.
REQ-029 SHALL, in LOCKED, consider only valid_i[owner] as candidate; other requesters receive ready_o=0 regardless of valid_i.
REQ-030 SHALL, in LOCKED, on accept with last_i[owner]=1, return to IDLE and set ptr <= (owner+1) mod N; ptr unchanged while LOCKED.
REQ-031 SHALL, when HS_ARB_LOCK_EN is undefined, omit last_i, FSM and owner; every beat is arbitrated independently per REQ-015/REQ-020.

Verification
REQ-032 SHALL cover: reset, valid_i=4'b1111, ready_i=1 steady -> gnt_id_o sequence 0,1,2,3,0 on consecutive valid_o cycles, no bubbles.
REQ-033 SHALL cover: valid_i=4'b0101, ready_i=0 for 3 cycles after first accept -> valid_o=1, dout and gnt_id_o=0 stable, ready_o=0 all 3 cycles; ready_i=1 -> next gnt_id_o=2.
REQ-034 SHALL cover: ptr=3, only valid_i[1]=1 -> ready_o=4'b0010, gnt_id_o=1 next cycle, ptr becomes 2.
REQ-035 SHALL cover: valid_i=0 while full and ready_i=1 -> valid_o drops to 0 next cycle, dout holds last value.
REQ-036 SHALL cover (HS_ARB_LOCK_EN): requester 2 sends 3 beats last_i=0,0,1 while requester 0 valid -> all 3 beats gnt_id_o=2 consecutively, then gnt_id_o=0.
REQ-037 SHALL cover: rst_n pulsed low while LOCKED mid-packet -> valid_o=0 immediately, after release requester 0 wins first.

Source files
------------

// File: rtl/hs_rr_arbiter.sv
`default_nettype none
// =============================================================================
// hs_rr_arbiter : N-to-1 round-robin valid/ready arbiter with one output register
//                 stage. Define HS_ARB_LOCK_EN to enable packet lock on last_i.
// Revision      : 1.0 - initial release
// =============================================================================
module hs_rr_arbiter #(
   parameter int DW = 3,
   parameter int N  = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         valid_i,
   output logic [N-1:0]         ready_o,
   input  logic [N*DW-1:0]      din,
`ifdef HS_ARB_LOCK_EN
   input  logic [N-1:0]         last_i,
`endif
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic [DW-1:0]        dout,
   output logic [$clog2(N)-1:0] gnt_id_o
);

   localparam int            IW  = $clog2(N);
   localparam logic [IW:0]   N_W = (IW+1)'(N);

   logic          full_q, full_d;
   logic [DW-1:0] dout_q, dout_d;
   logic [IW-1:0] gnt_q,  gnt_d;
   logic [IW-1:0] ptr_q,  ptr_d;

   logic          wr_en;
   logic          found;
   logic          accept;
   logic [IW-1:0] winner;
   logic [IW-1:0] ptr_next;
   logic [IW:0]   sum;
   logic [IW:0]   wrap;
   logic [N-1:0]  cand;

`ifdef HS_ARB_LOCK_EN
   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } lock_state_t;

   lock_state_t   state_q, state_d;
   logic [IW-1:0] owner_q, owner_d;
   logic [N-1:0]  owner_mask;

   // While a packet is in flight only its owner may compete.
   always_comb begin
      owner_mask          = '0;
      owner_mask[owner_q] = 1'b1;
      cand                = (state_q == LOCKED) ? (valid_i & owner_mask) : valid_i;
   end
`else
   always_comb begin
      cand = valid_i;
   end
`endif

   assign wr_en  = ~full_q | ready_i;
   assign accept = wr_en & found;

   // Scan candidates starting at ptr_q, wrapping modulo N.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      sum    = '0;
      for (int i = 0; i < N; i++) begin
         sum = {1'b0, ptr_q} + (IW+1)'(i);
         if (sum >= N_W) begin
            sum = sum - N_W;
         end
         if (!found && cand[sum[IW-1:0]]) begin
            found  = 1'b1;
            winner = sum[IW-1:0];
         end
      end
   end

   always_comb begin
      wrap     = {1'b0, winner} + (IW+1)'(1);
      ptr_next = (wrap == N_W) ? '0 : wrap[IW-1:0];
   end

   always_comb begin
      ready_o = '0;
      for (int k = 0; k < N; k++) begin
         ready_o[k] = rst_n & accept & (winner == IW'(k));
      end
   end

   always_comb begin
      full_d = full_q;
      dout_d = dout_q;
      gnt_d  = gnt_q;
      ptr_d  = ptr_q;
      if (wr_en) begin
         if (found) begin
            full_d = 1'b1;
            dout_d = din[int'(winner)*DW +: DW];
            gnt_d  = winner;
            ptr_d  = ptr_next;
         end else begin
            full_d = 1'b0;
         end
      end
`ifdef HS_ARB_LOCK_EN
      state_d = state_q;
      owner_d = owner_q;
      if (accept) begin
         if (state_q == IDLE) begin
            if (!last_i[winner]) begin
               state_d = LOCKED;
               owner_d = winner;
               ptr_d   = ptr_q;
            end
         end else begin
            if (last_i[winner]) begin
               state_d = IDLE;
            end else begin
               ptr_d   = ptr_q;
            end
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q  <= 1'b0;
         dout_q  <= '0;
         gnt_q   <= '0;
         ptr_q   <= '0;
`ifdef HS_ARB_LOCK_EN
         state_q <= IDLE;
         owner_q <= '0;
`endif
      end else begin
         full_q  <= full_d;
         dout_q  <= dout_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
`ifdef HS_ARB_LOCK_EN
         state_q <= state_d;
         owner_q <= owner_d;
`endif
      end
   end

   assign valid_o  = full_q;
   assign dout     = dout_q;
   assign gnt_id_o = gnt_q;

endmodule
`default_nettype wire
